// File: rtl/nanov_spi_mem_arbiter.sv
// Arbitrates the nanoV fetch and load/store paths onto one bit-serial SPI memory.
// A finished fetch leaves the device selected so a sequential fetch goes straight to data.
module nanov_spi_mem_arbiter #(
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    input  logic                 if_abort,
    output logic                 if_valid,
    output logic [31:0]          if_data,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_ack,
    output logic [31:0]          d_rdata,
    output logic                 spi_select,
    output logic                 spi_out,
    input  logic                 spi_data_in,
    output logic [2:0]           state_dbg
);

    localparam int TXW = 8 + ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_STREAM = 3'd4,
        S_DESEL  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 owner_q, owner_d;   // 1 = data path owns the bus
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [TXW-1:0]       tx_q, tx_d;
    logic [31:0]          sh_q, sh_d;
    logic                 if_valid_d, d_ack_d;
    logic [31:0]          if_data_d, d_rdata_d;

    logic [ADDR_BITS-1:0] fetch_word, data_word, next_seq;
    logic [31:0]          rx_word;
    logic                 abort_hit;
    logic                 unused_low_bits;

    assign fetch_word      = {if_addr[ADDR_BITS-1:2], 2'b00};
    assign data_word       = {d_addr[ADDR_BITS-1:2], 2'b00};
    assign next_seq        = addr_q + ADDR_BITS'(4);
    assign rx_word         = {spi_data_in, sh_q[31:1]};
    assign unused_low_bits = ^{if_addr[1:0], d_addr[1:0]};
    assign state_dbg       = state_q;

    assign abort_hit = if_abort && !owner_q &&
                       (state_q == S_CMD || state_q == S_ADDR ||
                        state_q == S_DATA || state_q == S_STREAM);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            tx_q     <= '0;
            sh_q     <= '0;
            if_valid <= 1'b0;
            if_data  <= '0;
            d_ack    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            sh_q     <= sh_d;
            if_valid <= if_valid_d;
            if_data  <= if_data_d;
            d_ack    <= d_ack_d;
            d_rdata  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 6'd1;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        tx_d       = {tx_q[TXW-2:0], 1'b0};
        sh_d       = sh_q;
        if_valid_d = 1'b0;
        if_data_d  = if_data;
        d_ack_d    = 1'b0;
        d_rdata_d  = d_rdata;

        case (state_q)
            S_IDLE, S_DESEL: begin
                state_d = S_IDLE;
                // d_req is still held during its own ack cycle; that is the old request.
                if (d_req && !d_ack) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    owner_d = 1'b1;
                    we_d    = d_we;
                    addr_d  = data_word;
                    tx_d    = {(d_we ? WRITE_CMD : READ_CMD), data_word};
                    sh_d    = d_wdata;
                end else if (if_req) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = fetch_word;
                    tx_d    = {READ_CMD, fetch_word};
                end
            end
            S_CMD: begin
                if (cnt_q == 6'd7) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (cnt_q == 6'(ADDR_BITS - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                sh_d = we_q ? {1'b0, sh_q[31:1]} : rx_word;
                if (cnt_q == 6'd31) begin
                    cnt_d = '0;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = rx_word;
                        state_d = S_DESEL;
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = rx_word;
                        state_d    = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                cnt_d = '0;
                if (d_req) begin
                    state_d = S_DESEL;
                // During the valid pulse the requester may still show the address just served.
                end else if (if_req && !(if_valid && fetch_word == addr_q)) begin
                    if (fetch_word == next_seq) begin
                        state_d = S_DATA;
                        addr_d  = next_seq;
                    end else begin
                        state_d = S_DESEL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_hit) begin
            state_d    = S_DESEL;
            if_valid_d = 1'b0;
            if_data_d  = if_data;
        end
    end

    always_comb begin
        spi_select = 1'b1;
        spi_out    = 1'b0;
        case (state_q)
            S_CMD, S_ADDR: begin
                spi_select = 1'b0;
                spi_out    = tx_q[TXW-1];
            end
            S_DATA: begin
                spi_select = 1'b0;
                spi_out    = owner_q && we_q && sh_q[0];
            end
            S_STREAM: spi_select = 1'b0;
            default: begin
                spi_select = 1'b1;
                spi_out    = 1'b0;
            end
        endcase
    end

endmodule
